mdio_master_cfg: RTL and testbench

- Parametrised MDIO management master that replaces the fixed management interface bundled with the Ethernet MAC. It lets the Nios host or fabric logic reach any PHY register directly.
- Serialises Clause 22 frames, and Clause 45 frames when enabled, onto mdc/mdio using a valid/ready command channel and a single-cycle response pulse.
- Sits between the CPU-side register bridge and the top-level MDIO pads.
- Bit rate, preamble length and Clause 45 support are set at build time.

---
 rtl/mdio_master_cfg_if.sv | 24 ++
 rtl/mdio_master_cfg.sv | 207 ++++++++++++++++++++
 tb/tb_mdio_master_cfg.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_master_cfg_if.sv
// Command/response channel between the register bridge and the MDIO master.
// The master modport is the requesting side; the MDIO block uses slave.
interface mdio_master_cfg_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_c45;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output cmd_valid, cmd_c45, cmd_op, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_c45, cmd_op, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mdio_master_cfg.sv
// MDIO management master: serialises Clause 22 (and optionally Clause 45) frames
// onto mdc/mdio from a valid/ready command channel with a one-cycle response pulse.
module mdio_master_cfg #(
  parameter int unsigned CLK_DIV      = 10,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter bit          C45_EN       = 1'b0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  mdio_master_cfg_if.slave bus,
  output logic             busy,
  output logic             mdc,
  input  logic             mdio_in,
  output logic             mdio_out,
  output logic             mdio_oen
);

  typedef enum logic [2:0] {StIdle, StPre, StHdr, StTa, StData, StDone} state_e;

  localparam logic [8:0] PhaseLast = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] SamplePh  = 9'(CLK_DIV - 1);
  localparam logic [8:0] MdcHigh   = 9'(CLK_DIV);
  localparam logic [5:0] PreLast   = (PREAMBLE_LEN == 0) ? 6'd0 : 6'(PREAMBLE_LEN - 1);

  state_e      state_q, state_d;
  logic [8:0]  phase_q, phase_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [13:0] hdr_q, hdr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic [15:0] shift_q, shift_d;
  logic        ta_err_q, ta_err_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic        mdc_q, mdc_d;
  logic        mdio_out_q, mdio_out_d;
  logic        mdio_oen_q, mdio_oen_d;

  logic accept, is_c45, cmd_rd, cmd_legal, bit_end, frame_d;

  assign accept    = (state_q == StIdle) && bus.cmd_valid && cmd_ready_q;
  assign is_c45    = C45_EN && bus.cmd_c45;
  assign cmd_rd    = is_c45 ? bus.cmd_op[1] : (bus.cmd_op == 2'b10);
  assign cmd_legal = is_c45 || (bus.cmd_op == 2'b01) || (bus.cmd_op == 2'b10);
  assign bit_end   = (phase_q == PhaseLast);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    shift_d     = shift_q;
    ta_err_d    = ta_err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          hdr_d    = {(is_c45 ? 2'b00 : 2'b01), bus.cmd_op, bus.cmd_phy_addr, bus.cmd_reg_addr};
          wdata_d  = bus.cmd_wdata;
          rd_d     = cmd_rd;
          shift_d  = '0;
          ta_err_d = 1'b0;
          phase_d  = '0;
          cnt_d    = '0;
          if (!cmd_legal) begin
            // Illegal C22 opcode: answer immediately without touching the bus.
            state_d     = StDone;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
          end else begin
            state_d = (PREAMBLE_LEN != 0) ? StPre : StHdr;
          end
        end
      end
      StPre, StHdr, StTa, StData: begin
        phase_d = bit_end ? 9'd0 : phase_q + 9'd1;
        if ((phase_q == SamplePh) && rd_q) begin
          if ((state_q == StTa) && (cnt_q == 6'd1)) ta_err_d = mdio_in;
          if (state_q == StData) shift_d = {shift_q[14:0], mdio_in};
        end
        if (bit_end) begin
          cnt_d = cnt_q + 6'd1;
          if (state_q == StPre) begin
            if (cnt_q == PreLast) begin
              state_d = StHdr;
              cnt_d   = '0;
            end
          end else if (state_q == StHdr) begin
            hdr_d = {hdr_q[12:0], 1'b0};
            if (cnt_q == 6'd13) begin
              state_d = StTa;
              cnt_d   = '0;
            end
          end else if (state_q == StTa) begin
            if (cnt_q == 6'd1) begin
              state_d = StData;
              cnt_d   = '0;
            end
          end else begin
            wdata_d = {wdata_q[14:0], 1'b0};
            if (cnt_q == 6'd15) begin
              state_d     = StDone;
              cnt_d       = '0;
              rsp_valid_d = 1'b1;
              rsp_rdata_d = rd_q ? shift_q : 16'h0000;
              rsp_error_d = rd_q && ta_err_q;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    frame_d     = state_d inside {StPre, StHdr, StTa, StData};
    mdc_d       = frame_d && (phase_d >= MdcHigh);
    cmd_ready_d = (state_d == StIdle);
    mdio_out_d  = mdio_out_q;
    mdio_oen_d  = mdio_oen_q;
    if (!frame_d) begin
      mdio_out_d = 1'b1;
      mdio_oen_d = 1'b1;
    end else if (phase_d == 9'd0) begin
      // Pad changes only at the start of a bit, on the MDC-low side.
      case (state_d)
        StPre: begin
          mdio_out_d = 1'b1;
          mdio_oen_d = 1'b0;
        end
        StHdr: begin
          mdio_out_d = hdr_d[13];
          mdio_oen_d = 1'b0;
        end
        StTa: begin
          mdio_out_d = rd_d ? 1'b1 : ~cnt_d[0];
          mdio_oen_d = rd_d;
        end
        StData: begin
          mdio_out_d = rd_d ? 1'b1 : wdata_d[15];
          mdio_oen_d = rd_d;
        end
        default: begin
          mdio_out_d = 1'b1;
          mdio_oen_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      cnt_q       <= '0;
      hdr_q       <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      shift_q     <= '0;
      ta_err_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_out_q  <= 1'b1;
      mdio_oen_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      shift_q     <= shift_d;
      ta_err_q    <= ta_err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      mdc_q       <= mdc_d;
      mdio_out_q  <= mdio_out_d;
      mdio_oen_q  <= mdio_oen_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign busy          = (state_q != StIdle);
  assign mdc           = mdc_q;
  assign mdio_out      = mdio_out_q;
  assign mdio_oen      = mdio_oen_q;

endmodule

// File: tb/tb_mdio_master_cfg.sv
// Bench for mdio_master_cfg: two instances (C22 with full preamble, C45 with none)
// checked against a frame-level model of the expected MDIO bit stream and response.
module tb_mdio_master_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mdio_master_cfg_if ifa ();
  mdio_master_cfg_if ifb ();

  logic        sel;
  logic        tb_valid, tb_c45, tb_mdio_in;
  logic [1:0]  tb_op;
  logic [4:0]  tb_phy, tb_reg;
  logic [15:0] tb_wdata;
  logic        busy_a, mdc_a, out_a, oen_a;
  logic        busy_b, mdc_b, out_b, oen_b;

  assign ifa.cmd_valid    = tb_valid & ~sel;
  assign ifb.cmd_valid    = tb_valid & sel;
  assign ifa.cmd_c45      = tb_c45;
  assign ifb.cmd_c45      = tb_c45;
  assign ifa.cmd_op       = tb_op;
  assign ifb.cmd_op       = tb_op;
  assign ifa.cmd_phy_addr = tb_phy;
  assign ifb.cmd_phy_addr = tb_phy;
  assign ifa.cmd_reg_addr = tb_reg;
  assign ifb.cmd_reg_addr = tb_reg;
  assign ifa.cmd_wdata    = tb_wdata;
  assign ifb.cmd_wdata    = tb_wdata;

  mdio_master_cfg #(.CLK_DIV(2), .PREAMBLE_LEN(32), .C45_EN(1'b0)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .bus(ifa), .busy(busy_a), .mdc(mdc_a),
    .mdio_in(tb_mdio_in), .mdio_out(out_a), .mdio_oen(oen_a)
  );

  mdio_master_cfg #(.CLK_DIV(3), .PREAMBLE_LEN(0), .C45_EN(1'b1)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .bus(ifb), .busy(busy_b), .mdc(mdc_b),
    .mdio_in(tb_mdio_in), .mdio_out(out_b), .mdio_oen(oen_b)
  );

  logic        o_ready, o_rsp, o_err, o_busy, o_mdc, o_out, o_oen;
  logic [15:0] o_rdata;
  assign o_ready = sel ? ifb.cmd_ready : ifa.cmd_ready;
  assign o_rsp   = sel ? ifb.rsp_valid : ifa.rsp_valid;
  assign o_err   = sel ? ifb.rsp_error : ifa.rsp_error;
  assign o_rdata = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_mdc   = sel ? mdc_b : mdc_a;
  assign o_out   = sel ? out_b : out_a;
  assign o_oen   = sel ? oen_b : oen_a;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned acc_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a command and returns at the negedge just after it was accepted.
  task automatic send_cmd(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] rega, input logic [15:0] wdata, output bit ok);
    tb_c45 = c45; tb_op = op; tb_phy = phy; tb_reg = rega; tb_wdata = wdata;
    tb_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      tb_valid = 1'b0;
      return;
    end
    @(negedge clk);
    acc_cyc = cyc;
    tb_valid = 1'b0;
    check_eq("ready_after_accept", o_ready, 1'b0);
    check_eq("busy_after_accept", o_busy, 1'b1);
  endtask

  task automatic do_cmd(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] rega, input logic [15:0] wdata, input logic present,
                        input logic [15:0] rval);
    bit          exp_bit[64];
    bit          exp_drv[64];
    bit          pin[64];
    int          n, pre, div, bits, lat, exp_lat;
    bit          c45e, legal, rd, ok, got_rsp, prev;
    logic [13:0] hdr;
    logic [15:0] exp_rdata, g_rdata;
    logic        exp_err, g_err;

    pre   = sel ? 0 : 32;
    div   = sel ? 3 : 2;
    c45e  = sel && c45;
    legal = c45e || (op == 2'b01) || (op == 2'b10);
    rd    = c45e ? op[1] : (op == 2'b10);
    hdr   = {(c45e ? 2'b00 : 2'b01), op, phy, rega};
    n = 0;
    for (int i = 0; i < pre; i++) begin
      exp_bit[n] = 1; exp_drv[n] = 1; pin[n] = 1; n++;
    end
    for (int k = 13; k >= 0; k--) begin
      exp_bit[n] = hdr[k]; exp_drv[n] = 1; pin[n] = 1; n++;
    end
    for (int k = 0; k < 2; k++) begin
      exp_bit[n] = (k == 0); exp_drv[n] = !rd;
      pin[n] = (rd && k == 1 && present) ? 1'b0 : 1'b1;
      n++;
    end
    for (int k = 15; k >= 0; k--) begin
      exp_bit[n] = wdata[k]; exp_drv[n] = !rd;
      pin[n] = (rd && present) ? rval[k] : 1'b1;
      n++;
    end
    exp_rdata = (legal && rd) ? (present ? rval : 16'hFFFF) : 16'h0000;
    exp_err   = !legal || (rd && !present);
    exp_lat   = legal ? (pre + 32) * 2 * div + 1 : 1;

    tb_mdio_in = pin[0];
    send_cmd(c45, op, phy, rega, wdata, ok);
    if (!ok) return;

    bits = 0; prev = 0; got_rsp = 0; lat = 0; g_rdata = '0; g_err = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (o_rsp) begin
        got_rsp = 1;
        lat = int'(cyc - acc_cyc) + 1;
        g_rdata = o_rdata;
        g_err = o_err;
        break;
      end
      if (o_mdc && !prev) begin
        if (bits < n) begin
          check_eq($sformatf("oen_bit%0d", bits), o_oen, !exp_drv[bits]);
          if (exp_drv[bits]) check_eq($sformatf("mdio_bit%0d", bits), o_out, exp_bit[bits]);
        end
        bits++;
        tb_mdio_in = (bits < n) ? pin[bits] : 1'b1;
      end
      prev = o_mdc;
      @(negedge clk);
    end
    check_eq("rsp_seen", got_rsp, 1'b1);
    if (!got_rsp) return;
    check_eq("latency", lat, exp_lat);
    check_eq("mdc_bits", bits, legal ? n : 0);
    check_eq("rsp_rdata", g_rdata, exp_rdata);
    check_eq("rsp_error", g_err, exp_err);
    check_eq("done_oen", o_oen, 1'b1);
    @(negedge clk);
    check_eq("rsp_one_cycle", o_rsp, 1'b0);
    check_eq("ready_after_rsp", o_ready, 1'b1);
    check_eq("idle_mdc", o_mdc, 1'b0);
    check_eq("rdata_hold", o_rdata, exp_rdata);
    tb_mdio_in = 1'b1;
  endtask

  task automatic rand_cmds(input int count);
    logic [31:0] r;
    for (int i = 0; i < count; i++) begin
      r = $urandom;
      do_cmd(r[0], r[2:1], r[7:3], r[12:8], r[28:13], r[29], 16'($urandom));
    end
  endtask

  task automatic mid_frame_reset();
    bit ok;
    int bits, rsp_cnt;
    bit prev;
    sel = 1'b0;
    tb_mdio_in = 1'b0;
    send_cmd(1'b0, 2'b10, 5'd3, 5'd2, 16'h0000, ok);
    if (!ok) return;
    bits = 0; prev = 0;
    for (int c = 0; c < 3000 && bits < 32 + 16 + 8; c++) begin
      @(negedge clk);
      if (o_mdc && !prev) bits++;
      prev = o_mdc;
    end
    check_eq("reset_point_reached", bits, 32 + 16 + 8);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_mdc", o_mdc, 1'b0);
    check_eq("midrst_oen", o_oen, 1'b1);
    check_eq("midrst_out", o_out, 1'b1);
    check_eq("midrst_busy", o_busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rsp_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_rsp) rsp_cnt++;
    end
    check_eq("midrst_no_rsp", rsp_cnt, 0);
    check_eq("midrst_ready_back", o_ready, 1'b1);
  endtask

  initial begin
    sel = 1'b0; tb_valid = 1'b0; tb_c45 = 1'b0; tb_op = 2'b00;
    tb_phy = '0; tb_reg = '0; tb_wdata = '0; tb_mdio_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mdc", mdc_a, 1'b0);
    check_eq("rst_out", out_a, 1'b1);
    check_eq("rst_oen", oen_a, 1'b1);
    check_eq("rst_ready", ifa.cmd_ready, 1'b0);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_rsp", {ifa.rsp_valid, ifa.rsp_error, ifa.rsp_rdata}, 18'h0);
    check_eq("rst_b_pads", {mdc_b, out_b, oen_b, ifb.cmd_ready}, 4'b0110);
    rst_n = 1'b1;
    #1;
    check_eq("ready_at_release", ifa.cmd_ready, 1'b0);
    @(negedge clk);
    check_eq("ready_one_after_release", ifa.cmd_ready, 1'b1);

    sel = 1'b0;
    do_cmd(1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b1, 16'h0000);
    do_cmd(1'b0, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b1, 16'h0022);
    do_cmd(1'b0, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b0, 16'h0000);
    do_cmd(1'b0, 2'b11, 5'h05, 5'h07, 16'h1234, 1'b1, 16'h0000);
    do_cmd(1'b1, 2'b00, 5'h05, 5'h07, 16'h1234, 1'b1, 16'h0000);
    rand_cmds(8);

    sel = 1'b1;
    do_cmd(1'b1, 2'b00, 5'h02, 5'h01, 16'h8000, 1'b1, 16'h0000);
    do_cmd(1'b1, 2'b11, 5'h02, 5'h01, 16'h0000, 1'b1, 16'hABCD);
    do_cmd(1'b0, 2'b01, 5'h1F, 5'h1F, 16'hA5C3, 1'b1, 16'h0000);
    do_cmd(1'b0, 2'b00, 5'h00, 5'h00, 16'h0000, 1'b1, 16'h0000);
    rand_cmds(10);

    mid_frame_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
